// File: rtl/subword_mem_ctrl_if.sv
// subword_mem_ctrl_if: pipeline request/response and word-memory signals of the MEM-stage controller
interface subword_mem_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        adel;
  logic        ades;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output busy, resp_valid, resp_rdata, adel, ades, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  busy, resp_valid, resp_rdata, adel, ades, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: MEM-stage controller with sub-word lane select/extension and read-modify-write stores
module subword_mem_ctrl #(
  parameter int          RD_LAT      = 1,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  subword_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {LW, LB, LBU, LH, LHU, SW, SB, SH} op_t;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
  if (RD_LAT != 1) begin : g_bad_lat
    $error("subword_mem_ctrl supports RD_LAT=1 only");
  end
  state_t      state;
  op_t         op;
  op_t         req_op;
  logic [1:0]  lane;
  logic [15:0] wd;
  logic        mis;
  logic        is_st;
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld;
  logic [31:0] merged;
  always_comb begin
    req_op = op_t'(bus.req_op);
    is_st  = req_op inside {SW, SB, SH};
    mis    = req_op inside {LW, SW} ? |bus.req_addr[1:0] :
             req_op inside {LH, LHU, SH} ? bus.req_addr[0] : 1'b0;
    sh     = {lane, 3'b000};
    b      = bus.mem_rdata[sh +: 8];
    h      = bus.mem_rdata[{lane[1], 4'b0000} +: 16];
    ld     = op == LW  ? bus.mem_rdata :
             op == LB  ? {{24{b[7]}}, b} :
             op == LBU ? {24'h0, b} :
             op == LH  ? {{16{h[15]}}, h} : {16'h0, h};
    // only the addressed lane is replaced; the rest of the word is written back as read
    merged = op == SB ? (bus.mem_rdata & ~(32'hff << sh)) | ({24'h0, wd[7:0]} << sh) :
             lane[1]  ? {wd, bus.mem_rdata[15:0]} : {bus.mem_rdata[31:16], wd};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op             <= LW;
      lane           <= 2'b00;
      wd             <= 16'h0;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= RESET_RDATA;
      bus.adel       <= 1'b0;
      bus.ades       <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.adel       <= 1'b0;
      bus.ades       <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          op   <= req_op;
          lane <= bus.req_addr[1:0];
          wd   <= bus.req_wdata[15:0];
          if (mis) begin
            bus.adel <= !is_st;
            bus.ades <= is_st;
          end else begin
            state         <= req_op == SW ? WR : RD;
            bus.busy      <= 1'b1;
            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
            bus.mem_re    <= req_op != SW;
            bus.mem_we    <= req_op == SW;
            bus.mem_wdata <= bus.req_wdata;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          state <= op inside {SB, SH} ? WR : DONE;
          if (op inside {SB, SH}) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= merged;
          end else begin
            bus.resp_rdata <= ld;
            bus.resp_valid <= 1'b1;
          end
        end
        WR: begin
          state          <= DONE;
          bus.resp_valid <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subword_mem_ctrl.sv
// tb_subword_mem_ctrl: directed vector table, corner sequences and random ops against an array-based memory model
module tb_subword_mem_ctrl;
  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, SW = 3'd5, SB = 3'd6, SH = 3'd7;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        mis;
  } vec_t;
  typedef struct {
    int          resp_cyc;
    int          resp_cnt;
    int          re_cyc;
    int          we_cyc;
    int          we_cnt;
    int          busy_end;
    int          adel_cnt;
    int          ades_cnt;
    int          exc_cyc;
    int          overlap;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] addr_seen;
  } obs_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  subword_mem_ctrl_if bus();
  subword_mem_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rd = 32'h0;
  int n_chk = 0;
  int n_err = 0;
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int re_c, output int we_c,
                       output logic [31:0] val, output logic ea, output logic es);
    logic [31:0] w, by, hf;
    int bsh, hsh;
    logic mis, st;
    w   = ref_mem[a[9:2]];
    bsh = 8 * int'(a % 4);
    hsh = 16 * int'((a / 2) % 2);
    by  = (w >> bsh) & 32'hFF;
    hf  = (w >> hsh) & 32'hFFFF;
    st  = op >= SW;
    mis = (op == LW || op == SW) ? (a % 4 != 0) : (op == LH || op == LHU || op == SH) ? (a % 2 != 0) : 1'b0;
    ea = mis && !st;
    es = mis && st;
    val = last_rd;
    lat = 0;
    re_c = 0;
    we_c = 0;
    if (!mis) begin
      case (op)
        LW:  val = w;
        LB:  val = by >= 128 ? by - 256 : by;
        LBU: val = by;
        LH:  val = hf >= 32768 ? hf - 65536 : hf;
        LHU: val = hf;
        SW:  val = wd;
        SB:  val = w - (by << bsh) + ((wd & 32'hFF) << bsh);
        default: val = w - (hf << hsh) + ((wd & 32'hFFFF) << hsh);
      endcase
      lat  = op == SW ? 2 : st ? 4 : 3;
      re_c = op == SW ? 0 : 1;
      we_c = op == SW ? 1 : st ? 3 : 0;
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        o.resp_cnt++;
        if (o.resp_cyc == 0) begin
          o.resp_cyc = k;
          o.rdata = bus.resp_rdata;
        end
      end
      if (bus.mem_re) begin
        if (o.re_cyc == 0) o.re_cyc = k;
        o.addr_seen = bus.mem_addr;
      end
      if (bus.mem_we) begin
        o.we_cnt++;
        if (o.we_cyc == 0) begin
          o.we_cyc = k;
          o.wdata = bus.mem_wdata;
        end
        o.addr_seen = bus.mem_addr;
      end
      if (bus.mem_re && bus.mem_we) o.overlap++;
      if (bus.adel) o.adel_cnt++;
      if (bus.ades) o.ades_cnt++;
      if ((bus.adel || bus.ades) && o.exc_cyc == 0) o.exc_cyc = k;
      if (!bus.busy && o.busy_end == 0) o.busy_end = k;
    end
  endtask
  task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, output obs_t o);
    int lat, re_c, we_c;
    logic [31:0] val;
    logic ea, es;
    model(op, a, wd, lat, re_c, we_c, val, ea, es);
    run(op, a, wd, o);
    chk("resp_cycle", o.resp_cyc, lat);
    chk("resp_count", o.resp_cnt, lat != 0 ? 1 : 0);
    chk("busy_release", o.busy_end, lat + 1);
    chk("re_cycle", o.re_cyc, re_c);
    chk("we_cycle", o.we_cyc, we_c);
    chk("we_count", o.we_cnt, we_c != 0 ? 1 : 0);
    chk("adel_count", o.adel_cnt, {31'b0, ea});
    chk("ades_count", o.ades_cnt, {31'b0, es});
    chk("exc_cycle", o.exc_cyc, (ea || es) ? 1 : 0);
    chk("re_we_overlap", o.overlap, 0);
    if (lat != 0) chk("mem_addr", o.addr_seen, a & 32'hFFFF_FFFC);
    if (lat != 0 && op < SW) begin
      chk("load_data", o.rdata, val);
      last_rd = val;
    end else begin
      chk("resp_rdata_hold", bus.resp_rdata, last_rd);
    end
    if (lat != 0 && op >= SW) begin
      chk("store_wdata", o.wdata, val);
      ref_mem[a[9:2]] = val;
      chk("mem_word", mem[a[9:2]], val);
    end
  endtask
  vec_t tbl[$];
  obs_t o;
  int   rcnt, recnt, wecnt, exccnt;
  int   rcyc [0:3];
  logic [31:0] rdat [0:3];
  initial begin
    tbl.push_back('{SW,  32'h100, 32'h80FF7F01, 32'h80FF7F01, 1'b0});
    tbl.push_back('{SW,  32'h200, 32'h11223344, 32'h11223344, 1'b0});
    tbl.push_back('{LB,  32'h100, 32'h0,        32'h00000001, 1'b0});
    tbl.push_back('{LB,  32'h101, 32'h0,        32'h0000007F, 1'b0});
    tbl.push_back('{LB,  32'h102, 32'h0,        32'hFFFFFFFF, 1'b0});
    tbl.push_back('{LB,  32'h103, 32'h0,        32'hFFFFFF80, 1'b0});
    tbl.push_back('{LBU, 32'h102, 32'h0,        32'h000000FF, 1'b0});
    tbl.push_back('{LH,  32'h102, 32'h0,        32'hFFFF80FF, 1'b0});
    tbl.push_back('{LHU, 32'h102, 32'h0,        32'h000080FF, 1'b0});
    tbl.push_back('{LH,  32'h100, 32'h0,        32'h00007F01, 1'b0});
    tbl.push_back('{SB,  32'h201, 32'hAAAAAAEE, 32'h1122EE44, 1'b0});
    tbl.push_back('{LW,  32'h200, 32'h0,        32'h1122EE44, 1'b0});
    tbl.push_back('{SH,  32'h202, 32'h0000BEEF, 32'hBEEFEE44, 1'b0});
    tbl.push_back('{LW,  32'h200, 32'h0,        32'hBEEFEE44, 1'b0});
    tbl.push_back('{LW,  32'h101, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{SH,  32'h203, 32'h1234,     32'h0,        1'b1});
    tbl.push_back('{LB,  32'h103, 32'h0,        32'hFFFFFF80, 1'b0});
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_adel", bus.adel, 0);
    chk("rst_ades", bus.ades, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      do_txn(tbl[i].op, tbl[i].a, tbl[i].wd, o);
      if (tbl[i].mis) chk("tbl_exception", o.adel_cnt + o.ades_cnt, 1);
      else if (tbl[i].op < SW) chk("tbl_load", o.rdata, tbl[i].exp);
      else chk("tbl_store", o.wdata, tbl[i].exp);
    end
    // request held through busy, including the DONE cycle, must be taken exactly once on the next IDLE cycle
    rcnt = 0;
    recnt = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h100;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_addr = 32'h200;
      if (k == 4) chk("stall_idle_gap", bus.busy, 0);
      if (k == 5) bus.req_valid = 1'b0;
      if (bus.mem_re) recnt++;
      if (bus.resp_valid && rcnt < 4) begin
        rcyc[rcnt] = k;
        rdat[rcnt] = bus.resp_rdata;
        rcnt++;
      end
    end
    chk("stall_resp_count", rcnt, 2);
    chk("stall_read_count", recnt, 2);
    if (rcnt == 2) begin
      chk("stall_resp1_cycle", rcyc[0], 3);
      chk("stall_resp1_data", rdat[0], ref_mem[8'h40]);
      chk("stall_resp2_cycle", rcyc[1], 7);
      chk("stall_resp2_data", rdat[1], ref_mem[8'h80]);
    end
    last_rd = ref_mem[8'h80];
    // reset while an SB sits in WAIT must abandon the read-modify-write
    wecnt = 0;
    rcnt = 0;
    exccnt = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = SB;
    bus.req_addr  = 32'h201;
    bus.req_wdata = 32'h55;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.mem_we) wecnt++;
      if (bus.resp_valid) rcnt++;
      if (bus.adel || bus.ades) exccnt++;
      if (k == 2) begin
        chk("rst_mid_busy_before", bus.busy, 1);
        reset = 1'b1;
      end
      if (k == 3) begin
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_resp_rdata", bus.resp_rdata, 0);
        reset = 1'b0;
      end
    end
    chk("rst_mid_no_write", wecnt, 0);
    chk("rst_mid_no_resp", rcnt, 0);
    chk("rst_mid_no_exc", exccnt, 0);
    chk("rst_mid_mem_kept", mem[8'h80], ref_mem[8'h80]);
    last_rd = 32'h0;
    do_txn(LB, 32'h201, 32'h0, o);
    chk("post_rst_lb", o.rdata, 32'hFFFFFFEE);
    for (int i = 0; i < 16; i++) do_txn(SW, 32'h300 + 32'(4 * i), $urandom, o);
    for (int i = 0; i < 80; i++)
      do_txn(3'($urandom_range(0, 7)), 32'h300 + 32'($urandom_range(0, 63)), $urandom, o);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
